// File: rtl/vector_load_pkg.sv
// vector_load_pkg: shared state encoding and packing constants for the vector load sequencer.
`default_nettype none

package vector_load_pkg;

  localparam int LANES      = 4;
  localparam int MUL_GROUPS = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_MUL = 3'd1,
    S_LOAD_PXL = 3'd2,
    S_WB       = 3'd3,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5
  } load_state_t;

endpackage

`default_nettype wire

// File: rtl/lane_packer.sv
// lane_packer: gathers four accepted stream words into one 4-lane holding register
// and raises a strobe for the single cycle that follows the fourth word.
`default_nettype none

module lane_packer
  import vector_load_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       accept_i,
  input  logic [31:0]                data_i,
  output logic                       last_o,
  output logic                       strobe_o,
  output logic [LANES-1:0][31:0]     lanes_o
);

  logic [1:0]                idx_q;
  logic [LANES-2:0][31:0]    stage_q;
  logic [LANES-1:0][31:0]    hold_q;
  logic                      strobe_q;

  assign last_o   = accept_i && (idx_q == 2'(LANES - 1));
  assign strobe_o = strobe_q;
  assign lanes_o  = hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= '0;
      stage_q  <= '0;
      hold_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= last_o;
      if (accept_i) begin
        idx_q <= idx_q + 2'd1;
        case (idx_q)
          2'd0:    stage_q[0] <= data_i;
          2'd1:    stage_q[1] <= data_i;
          2'd2:    stage_q[2] <= data_i;
          // Lane 0 holds the first word of the group.
          default: hold_q     <= {data_i, stage_q[2], stage_q[1], stage_q[0]};
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vector_load_sequencer.sv
// vector_load_sequencer: streams coefficients then pixel pairs into vector_cpu,
// gating the CPU for a fixed drain window after each pixel pair.
`default_nettype none

module vector_load_sequencer
  import vector_load_pkg::*;
#(
  parameter int GRP_W      = 16,
  parameter int RUN_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [GRP_W-1:0] num_groups,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             we_mul,
  output logic             wr_mul_pos,
  output logic [31:0]      wdm1,
  output logic [31:0]      wdm2,
  output logic [31:0]      wdm3,
  output logic [31:0]      wdm4,
  output logic             we_pxl,
  output logic             wr_pos_pxl,
  output logic [31:0]      wdp1,
  output logic [31:0]      wdp2,
  output logic [31:0]      wdp3,
  output logic [31:0]      wdp4,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [GRP_W-1:0] grp_cnt
);

  load_state_t            state_q, state_d;
  logic [GRP_W-1:0]       num_q, num_d;
  logic [GRP_W-1:0]       grp_q, grp_d;
  logic                   slot_q, slot_d;
  logic                   mul_grp_q, mul_grp_d;
  logic [7:0]             run_q, run_d;
  logic                   sel_pxl_q, sel_pxl_d;
  logic                   pos_q, pos_d;

  logic                   pk_last;
  logic                   pk_strobe;
  logic [LANES-1:0][31:0] pk_lanes;

  lane_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .accept_i (s_valid && s_ready),
    .data_i   (s_data),
    .last_o   (pk_last),
    .strobe_o (pk_strobe),
    .lanes_o  (pk_lanes)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      grp_q     <= '0;
      slot_q    <= 1'b0;
      mul_grp_q <= 1'b0;
      run_q     <= '0;
      sel_pxl_q <= 1'b0;
      pos_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      grp_q     <= grp_d;
      slot_q    <= slot_d;
      mul_grp_q <= mul_grp_d;
      run_q     <= run_d;
      sel_pxl_q <= sel_pxl_d;
      pos_q     <= pos_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    grp_d     = grp_q;
    slot_d    = slot_q;
    mul_grp_d = mul_grp_q;
    run_d     = run_q;
    sel_pxl_d = sel_pxl_q;
    pos_d     = pos_q;
    s_ready   = 1'b0;
    cpu_en    = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d     = num_groups;
          grp_d     = '0;
          slot_d    = 1'b0;
          mul_grp_d = 1'b0;
          run_d     = '0;
          state_d   = S_LOAD_MUL;
        end
      end
      S_LOAD_MUL: begin
        s_ready = 1'b1;
        if (pk_last) begin
          sel_pxl_d = 1'b0;
          pos_d     = mul_grp_q;
          mul_grp_d = ~mul_grp_q;
          if (mul_grp_q == 1'(MUL_GROUPS - 1)) begin
            state_d = (num_q == '0) ? S_DONE : S_LOAD_PXL;
          end
        end
      end
      S_LOAD_PXL: begin
        s_ready = 1'b1;
        if (pk_last) begin
          sel_pxl_d = 1'b1;
          pos_d     = slot_q;
          slot_d    = ~slot_q;
          grp_d     = grp_q + GRP_W'(1);
          // A batch ends on a full pair or on the frame's final (odd) group.
          if (slot_q || ((grp_q + GRP_W'(1)) == num_q)) begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        cpu_en = 1'b1;
        if (run_q == 8'(RUN_CYCLES - 1)) begin
          run_d   = '0;
          slot_d  = 1'b0;
          state_d = (grp_q == num_q) ? S_DONE : S_LOAD_PXL;
        end else begin
          run_d = run_q + 8'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign we_mul     = pk_strobe & ~sel_pxl_q;
  assign we_pxl     = pk_strobe &  sel_pxl_q;
  assign wr_mul_pos = we_mul & pos_q;
  assign wr_pos_pxl = we_pxl & pos_q;
  assign grp_cnt    = grp_q;

  assign wdm1 = pk_lanes[0];
  assign wdm2 = pk_lanes[1];
  assign wdm3 = pk_lanes[2];
  assign wdm4 = pk_lanes[3];
  assign wdp1 = pk_lanes[0];
  assign wdp2 = pk_lanes[1];
  assign wdp3 = pk_lanes[2];
  assign wdp4 = pk_lanes[3];

endmodule

`default_nettype wire

// File: tb/tb_vector_load_sequencer.sv
// tb_vector_load_sequencer: randomized frames against a queue-based frame model.
`default_nettype none

module tb_vector_load_sequencer;

  localparam int GRP_W      = 16;
  localparam int RUN_CYCLES = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [GRP_W-1:0] num_groups;
  logic             s_valid;
  logic [31:0]      s_data;
  logic             s_ready;
  logic             we_mul, wr_mul_pos, we_pxl, wr_pos_pxl;
  logic [31:0]      wdm1, wdm2, wdm3, wdm4, wdp1, wdp2, wdp3, wdp4;
  logic             cpu_en, busy, done;
  logic [GRP_W-1:0] grp_cnt;

  vector_load_sequencer #(.GRP_W(GRP_W), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_groups (num_groups),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .we_mul     (we_mul),
    .wr_mul_pos (wr_mul_pos),
    .wdm1       (wdm1),
    .wdm2       (wdm2),
    .wdm3       (wdm3),
    .wdm4       (wdm4),
    .we_pxl     (we_pxl),
    .wr_pos_pxl (wr_pos_pxl),
    .wdp1       (wdp1),
    .wdp2       (wdp2),
    .wdp3       (wdp3),
    .wdp4       (wdp4),
    .cpu_en     (cpu_en),
    .busy       (busy),
    .done       (done),
    .grp_cnt    (grp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         pxl;
    logic         pos;
    logic [127:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cpu_cnt   = 0;
  int  done_cnt  = 0;
  int  words_acc = 0;
  bit  pend      = 1'b0;
  logic mon_str;
  ev_t  mon_a, mon_e;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h need %0h", nm, act, req);
    end
  endtask

  // Monitor: strobe latency, strobe contents, cpu_en/done tallies.
  always @(negedge clk) begin
    if (!rst) begin
      words_acc = 0;
      pend      = 1'b0;
    end else begin
      mon_str = we_mul | we_pxl;
      if (mon_str || pend) chk("strobe_latency", mon_str, pend);
      if (mon_str) begin
        chk("strobe_exclusive", we_mul & we_pxl, 0);
        mon_a.pxl = we_pxl;
        mon_a.pos = we_pxl ? wr_pos_pxl : wr_mul_pos;
        mon_a.d   = we_pxl ? {wdp4, wdp3, wdp2, wdp1} : {wdm4, wdm3, wdm2, wdm1};
        chk("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("strobe_kind_pos", {mon_a.pxl, mon_a.pos}, {mon_e.pxl, mon_e.pos});
          chk("strobe_lanes", mon_a.d, mon_e.d);
        end
      end
      if (cpu_en) cpu_cnt++;
      if (done) done_cnt++;
      if (s_ready) chk("ready_implies_busy", busy, 1);
      if (s_valid && s_ready) begin
        words_acc++;
        pend = (words_acc % 4 == 0);
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input bit bp, input bit allow_start);
    bit rdy;
    int b;
    if (bp && ($urandom_range(0, 1) == 1)) begin
      s_valid = 1'b0;
      if (allow_start) begin
        start      = 1'b1;
        num_groups = GRP_W'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    s_valid = 1'b1;
    s_data  = w;
    b = 0;
    forever begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk); #1;
      if (rdy) break;
      b++;
      if (b > 1000) begin
        chk("word_accept_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Frame model: two coefficient groups, then pixel groups paired into slots 0/1.
  task automatic run_frame(input int n, input bit bp, input bit directed, input bit abort);
    logic [31:0] w[$];
    ev_t         e;
    int          nw;
    int          b;
    nw = 8 + 4 * n;
    w.delete();
    for (int i = 0; i < nw; i++) begin
      if (directed) w.push_back((i < 8) ? 32'(i + 1) : 32'(32'h10 + i - 8));
      else          w.push_back($urandom);
    end
    for (int g = 0; g < 2 + n; g++) begin
      e.pxl = (g >= 2);
      e.pos = (g < 2) ? g[0] : ((g - 2) % 2 == 1);
      e.d   = {w[4*g+3], w[4*g+2], w[4*g+1], w[4*g]};
      exp_q.push_back(e);
    end
    cpu_cnt  = 0;
    done_cnt = 0;
    start      = 1'b1;
    num_groups = GRP_W'(n);
    @(posedge clk); #1;
    start      = 1'b0;
    num_groups = GRP_W'($urandom);
    for (int i = 0; i < nw; i++) send_word(w[i], bp, bp && (i > 0));
    s_valid = 1'b0;

    if (abort) begin
      b = 0;
      while (cpu_cnt < 2 && b < 2000) begin
        @(posedge clk);
        b++;
      end
      chk("abort_reached_run", cpu_cnt >= 2, 1);
      #3;
      rst = 1'b0;
      #1;
      chk("abort_cpu_en", cpu_en, 0);
      chk("abort_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      return;
    end

    b = 0;
    while (done_cnt == 0 && b < 2000) begin
      @(posedge clk);
      b++;
    end
    chk("done_seen", done_cnt != 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("grp_cnt_final", grp_cnt, n);
    chk("cpu_en_cycles", cpu_cnt, ((n + 1) / 2) * RUN_CYCLES);
    chk("idle_after_done", busy, 0);
    chk("all_strobes_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    num_groups = '0;
    s_valid    = 1'b1;
    s_data     = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl_outputs", {s_ready, we_mul, we_pxl, cpu_en, busy, done, wr_mul_pos, wr_pos_pxl}, 0);
    chk("rst_grp_cnt", grp_cnt, 0);
    chk("rst_wd", {wdm4, wdm3, wdm2, wdm1}, 0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_no_start_busy", busy, 0);
    chk("idle_no_start_ready", s_ready, 0);

    run_frame(0, 1'b0, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b1, 1'b0);
    run_frame(3, 1'b0, 1'b0, 1'b0);
    run_frame(4, 1'b1, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b1);
    run_frame(1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_frame($urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vector_load_sequencer.md
Name: vector_load_sequencer

Overview:
- Host-side front end for vector_cpu: accepts a 32-bit word stream over valid/ready and packs it into 4-lane writes.
- Drives the CPU's coefficient-load ports (we_mul, wr_mul_pos_in, wdm1..4) and pixel-load ports (we_pxl, wr_pos_pxl, wdp1..4).
- After every pixel-register pair is loaded, gates the CPU (cpu_en) for a fixed pipeline-drain window, then resumes loading.
- Signals done when the whole frame has been processed.

Parameters:
- GRP_W, 16, width of group count / group counter
- RUN_CYCLES, 5, cpu_en high cycles per pixel-pair batch (IF→WB depth); legal range 1..255

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- num_groups  in  GRP_W  4-pixel groups in frame; captured on accepted start
- s_valid  in  1  stream word valid
- s_data  in  32  stream word
- s_ready  out  1  stream word accepted when s_valid && s_ready
- we_mul  out  1  coefficient-register write strobe
- wr_mul_pos  out  1  coefficient bank (0 = words 0-3, 1 = words 4-7)
- wdm1..wdm4  out  32 each  coefficient lanes (lane1 = first word of group)
- we_pxl  out  1  pixel-register write strobe
- wr_pos_pxl  out  1  pixel slot (0/1)
- wdp1..wdp4  out  32 each  pixel lanes
- cpu_en  out  1  CPU pipeline enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end
- grp_cnt  out  GRP_W  pixel groups written so far this frame

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; lane index, group counter, run counter and wd* holding registers cleared.
- States: IDLE, LOAD_MUL, LOAD_PXL, WB, RUN, DONE.
- s_ready = 1 only in LOAD_MUL and LOAD_PXL.
- IDLE: start=1 → capture num_groups, clear grp_cnt, go to LOAD_MUL.
- start in any other state is ignored.
- Packing:
  - 2-bit lane index increments on each accepted word.
  - On the 4th accepted word, all 4 lanes are copied into the wd* holding registers and the matching strobe is high for exactly the next cycle.
  - Strobe latency is 1 cycle. Back-to-back groups need no bubble; holding registers change only on a strobe.
- LOAD_MUL:
  - Group 0 → we_mul with wr_mul_pos=0; group 1 → wr_mul_pos=1.
  - After the 8th word: go to LOAD_PXL, or to DONE if num_groups==0.
- LOAD_PXL:
  - Each completed group raises we_pxl with wr_pos_pxl = slot toggle, which starts at 0 per frame.
  - grp_cnt increments in the strobe cycle.
  - Go to WB when a slot-1 group completes, or when the final group completes (odd count, slot 0).
- WB: one cycle. The pending we_pxl strobe fires here; s_ready=0; next state RUN.
- RUN:
  - cpu_en=1 for exactly RUN_CYCLES cycles.
  - Afterwards: DONE if grp_cnt==captured num_groups, else LOAD_PXL with slot reset to 0.
- DONE: done=1 for one cycle, busy=1 in that cycle, next state IDLE.
- cpu_en=0 in every state except RUN.
- wd* values persist after a strobe until the next strobe.
- s_valid held low mid-group: lane index holds, no timeout.
- Reset mid-frame: immediate abort. Partial group discarded; no strobe or done.
- num_groups max (2^GRP_W−1): grp_cnt never wraps within a frame.

Decomposition:
- Package vector_load_pkg:
  - state enum load_state_t
  - LANES=4, MUL_GROUPS=2 constants
- Sub-module lane_packer: lane index, 4×32 holding registers, 1-cycle strobe generation.
  - Instanced once; the FSM routes its strobe to we_mul or we_pxl.

Test Plan:
- Reset/idle: rst=0 with s_valid=1 → all outputs 0, s_ready=0; release with no start → busy stays 0.
- Coefficient load: start, num_groups=0, words 1..8 back-to-back → we_mul at cycles 5 (wdm=1,2,3,4, pos 0) and 9 (wdm=5,6,7,8, pos 1); then done pulse, no we_pxl, cpu_en never high.
- Even frame: num_groups=2, 8 coefficient words + pixel words 0x10..0x17 → we_pxl pos0 (wdp=0x10..0x13) then pos1 in WB (0x14..0x17); cpu_en high exactly 5 cycles; done; grp_cnt=2.
- Odd frame: num_groups=3 → batches of 2 then 1; second batch writes only pos0; cpu_en runs twice (10 cycles total); done once.
- Back-pressure/ignore: s_valid toggled every other cycle and start pulsed while busy → same wd*/strobe values as back-to-back, captured num_groups unchanged.
- Mid-run reset: rst low during RUN cycle 3 → cpu_en drops immediately, no done; a new frame then loads correctly from lane 0.
